tlp_tx_reader: RTL and testbench
================================

TLP_TX_READER -- requirements
Module: tlp_tx_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32; DW width, fixed at 32 for this revision.
REQ-002 SHALL have parameter CNT_WIDTH, default 16; width of the completed-packet counter.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 fifo_empty  input  1  registered Empty flag from the TLP buffer read side.
REQ-006 fifo_data  input  DATA_WIDTH  show-ahead (combinational) buffer head word; valid whenever fifo_empty=0.
REQ-007 fifo_rd_en  output  DATA_WIDTH-independent 1  pop strobe to the buffer; pointer advances on the same clock edge.
REQ-008 tlp_data  output  DATA_WIDTH  registered outgoing DW.
REQ-009 tlp_valid  output  1  tlp_data holds a valid DW.
REQ-010 tlp_ready  input  1  downstream accepts tlp_data when tlp_valid=1 and tlp_ready=1.
REQ-011 tlp_sop  output  1  current DW is DW0 (first header DW) of a TLP.
REQ-012 tlp_eop  output  1  current DW is the last DW of a TLP.
REQ-013 busy  output  1  1 while a TLP is partially popped (state STREAM).
REQ-014 pkt_done  output  1  single-cycle pulse when an eop DW is accepted downstream.
REQ-015 pkt_count  output  CNT_WIDTH  count of accepted eop DWs since reset.

Function
REQ-016 Output stage SHALL be one register slot: load_ok = !tlp_valid || tlp_ready.
REQ-017 fifo_rd_en SHALL be combinational: fifo_rd_en = !fifo_empty && load_ok; never asserted while fifo_empty=1.
REQ-018 On fifo_rd_en, tlp_data SHALL capture fifo_data and tlp_valid SHALL be 1 at the next edge; latency buffer head -> tlp_data is 1 cycle.
REQ-019 If tlp_valid && tlp_ready and no pop, tlp_valid SHALL clear at the next edge; if !tlp_ready, tlp_data/sop/eop SHALL hold unchanged.
REQ-020 FSM states: IDLE (next popped DW is DW0), STREAM (popping remaining DWs of current TLP).
REQ-021 In IDLE, a popped DW SHALL be decoded as DW0: fmt = bit[30:29], length = bit[9:0]; tlp_sop=1 for that DW.
REQ-022 Header DWs SHALL be 4 if fmt[0]=1 else 3; payload DWs = length if fmt[1]=1 else 0.
REQ-023 length field 0 with fmt[1]=1 SHALL mean 1024 payload DWs; remaining counter SHALL be 11 bits.
REQ-024 On DW0 pop: remaining <= total_DWs - 1, state <= STREAM; tlp_eop=0 (total is always >= 3).
REQ-025 In STREAM, each pop SHALL decrement remaining; pop with remaining=1 SHALL set tlp_eop=1, tlp_sop=0, state <= IDLE.
REQ-026 Non-final STREAM pops SHALL set tlp_sop=0, tlp_eop=0.
REQ-027 Back-to-back TLPs: the DW0 of the next TLP SHALL be poppable in the cycle immediately after the eop pop; no idle gap required.
REQ-028 Empty buffer mid-TLP SHALL stall popping with state and remaining preserved; stream resumes without loss or duplication.
REQ-029 Simultaneous downstream accept and pop in one cycle SHALL replace the slot contents with no bubble (full throughput 1 DW/cycle).
REQ-030 pkt_done SHALL pulse the cycle after tlp_valid && tlp_ready && tlp_eop; pkt_count SHALL increment at that edge, wrapping modulo 2^CNT_WIDTH.
REQ-031 busy SHALL equal (state == STREAM).

Reset
REQ-032 rst=0 SHALL asynchronously force: state=IDLE, remaining=0, tlp_valid=0, tlp_sop=0, tlp_eop=0, tlp_data=0, pkt_done=0, pkt_count=0.
REQ-033 Reset mid-TLP SHALL discard the partial TLP; after release the next DW popped SHALL be treated as DW0.
REQ-034 fifo_rd_en SHALL be 0 while rst=0.

Verification
REQ-035 3DW no-data TLP (DW0=0x0000_0001), tlp_ready=1 -> 3 DWs out on consecutive cycles, sop on DW1st, eop on DW3, pkt_count=1.
REQ-036 4DW write, DW0=0x6000_0002 -> 6 DWs out, eop on 6th; immediately followed by 3DW TLP -> its sop the cycle after first eop.
REQ-037 3DW write length=0 (DW0=0x4000_0000) -> 1027 DWs, eop on DW1027, busy high for 1026 accepted cycles.
REQ-038 tlp_ready held 0 for 5 cycles mid-TLP -> fifo_rd_en=0, tlp_data stable, no DW lost or repeated after release.
REQ-039 fifo_empty=1 for 4 cycles after DW2 of 4DW write length=1 -> tlp_valid drops, state STREAM held, remaining DWs delivered with eop on 5th.
REQ-040 rst asserted after DW2 of a 4DW TLP -> all outputs at reset values; next pushed DW0=0x0000_0001 decoded as fresh 3DW TLP.

Source files
------------

// File: rtl/tlp_tx_reader.sv
// tlp_tx_reader: pops TLP dwords from a show-ahead buffer into a single
// registered output slot. The first dword of each packet is decoded to learn
// how many dwords the packet has, so sop/eop can be marked and packet
// boundaries tracked without any sideband from the buffer.
module tlp_tx_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] tlp_data,
    output logic                  tlp_valid,
    input  logic                  tlp_ready,
    output logic                  tlp_sop,
    output logic                  tlp_eop,
    output logic                  busy,
    output logic                  pkt_done,
    output logic [CNT_WIDTH-1:0]  pkt_count
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t      state_r;
    logic [10:0] remain_r;
    logic        loadOk_s;
    logic        acceptEop_s;

    // Total dwords of a TLP from its DW0 fmt and length fields.
    // A zero length on a packet with data encodes the 1024-dword maximum.
    function automatic logic [10:0] tlpTotalDw(input logic [1:0] fmt,
                                               input logic [9:0] len);
        logic [10:0] hdrDw;
        logic [10:0] payDw;
        hdrDw = fmt[0] ? 11'd4 : 11'd3;
        if (fmt[1]) begin
            payDw = (len == 10'd0) ? 11'd1024 : {1'b0, len};
        end else begin
            payDw = 11'd0;
        end
        return hdrDw + payDw;
    endfunction

    // Pop strobe: the slot can take a new dword when empty or being drained.
    always_comb begin
        loadOk_s    = !tlp_valid || tlp_ready;
        acceptEop_s = tlp_valid && tlp_ready && tlp_eop;
        if (!rst) begin
            fifo_rd_en = 1'b0;
        end else begin
            fifo_rd_en = !fifo_empty && loadOk_s;
        end
    end

    // Packet framing FSM together with the output slot it loads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            remain_r  <= 11'd0;
            tlp_data  <= {DATA_WIDTH{1'b0}};
            tlp_valid <= 1'b0;
            tlp_sop   <= 1'b0;
            tlp_eop   <= 1'b0;
        end else if (fifo_rd_en) begin
            tlp_data  <= fifo_data;
            tlp_valid <= 1'b1;
            case (state_r)
                IDLE: begin
                    // Total is at least 3, so DW0 is never the last dword.
                    remain_r <= tlpTotalDw(fifo_data[30:29], fifo_data[9:0]) - 11'd1;
                    state_r  <= STREAM;
                    tlp_sop  <= 1'b1;
                    tlp_eop  <= 1'b0;
                end
                STREAM: begin
                    remain_r <= remain_r - 11'd1;
                    tlp_sop  <= 1'b0;
                    if (remain_r == 11'd1) begin
                        tlp_eop <= 1'b1;
                        state_r <= IDLE;
                    end else begin
                        tlp_eop <= 1'b0;
                        state_r <= STREAM;
                    end
                end
                default: begin
                    remain_r <= 11'd0;
                    state_r  <= IDLE;
                    tlp_sop  <= 1'b0;
                    tlp_eop  <= 1'b0;
                end
            endcase
        end else if (tlp_ready) begin
            // Slot drained with nothing to refill it; contents may go stale.
            tlp_valid <= 1'b0;
        end else begin
            // Downstream stalled: hold the slot exactly as it is.
            tlp_valid <= tlp_valid;
        end
    end

    // Completed-packet pulse and wrapping counter on eop acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_done  <= 1'b0;
            pkt_count <= {CNT_WIDTH{1'b0}};
        end else begin
            pkt_done <= acceptEop_s;
            if (acceptEop_s) begin
                pkt_count <= pkt_count + CNT_WIDTH'(1);
            end else begin
                pkt_count <= pkt_count;
            end
        end
    end

    assign busy = (state_r == STREAM);

endmodule

// File: tb/tb_tlp_tx_reader.sv
// Bench for tlp_tx_reader: a queue plays the TLP buffer, a word-level model
// tracks the output slot, busy and packet counts, and directed scenarios are
// followed by a randomized run with random backpressure and starvation.
module tb_tlp_tx_reader;

    typedef struct {
        logic [31:0] data;
        logic        first;
        logic        last;
    } entry_t;

    logic        clk;
    logic        rst;
    logic        fifo_empty;
    logic [31:0] fifo_data;
    logic        fifo_rd_en;
    logic [31:0] tlp_data;
    logic        tlp_valid;
    logic        tlp_ready;
    logic        tlp_sop;
    logic        tlp_eop;
    logic        busy;
    logic        pkt_done;
    logic [2:0]  pkt_count;

    entry_t fifoQ[$];
    entry_t expQ[$];
    logic   starve;

    int nChecks = 0;
    int nFail   = 0;
    int popCnt  = 0;
    int accBusy = 0;

    logic        mValid, mSop, mEop, mBusy, mDone;
    logic [31:0] mData;
    logic [2:0]  mCount;

    tlp_tx_reader #(.DATA_WIDTH(32), .CNT_WIDTH(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .tlp_data   (tlp_data),
        .tlp_valid  (tlp_valid),
        .tlp_ready  (tlp_ready),
        .tlp_sop    (tlp_sop),
        .tlp_eop    (tlp_eop),
        .busy       (busy),
        .pkt_done   (pkt_done),
        .pkt_count  (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packet length in dwords straight from the header rules.
    function automatic int tlpWords(input logic [31:0] dw0);
        int hdr;
        int pay;
        hdr = dw0[29] ? 4 : 3;
        if (dw0[30]) pay = (dw0[9:0] == 10'd0) ? 1024 : int'(dw0[9:0]);
        else         pay = 0;
        return hdr + pay;
    endfunction

    task automatic pushTlp(input logic [31:0] dw0);
        int n;
        entry_t e;
        n = tlpWords(dw0);
        for (int i = 0; i < n; i++) begin
            e.data  = (i == 0) ? dw0 : $urandom;
            e.first = (i == 0);
            e.last  = (i == n - 1);
            fifoQ.push_back(e);
            expQ.push_back(e);
        end
    endtask

    task automatic waitDrain(input int limit);
        int n;
        tlp_ready = 1'b1;
        starve    = 1'b0;
        n = 0;
        while ((expQ.size() != 0 || fifoQ.size() != 0) && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_left", 32'(expQ.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic waitPops(input int base, input int cnt);
        int n;
        n = 0;
        while (popCnt - base < cnt && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("pop_wait", 32'(popCnt - base), 32'(cnt));
    endtask

    // Buffer read side: head word and registered empty flag after each edge.
    initial begin
        forever begin
            @(posedge clk); #2;
            if (fifoQ.size() != 0 && !starve) begin
                fifo_empty = 1'b0;
                fifo_data  = fifoQ[0].data;
            end else begin
                fifo_empty = 1'b1;
                fifo_data  = $urandom;
            end
        end
    end

    // Compare process: check DUT against the model, then advance the model.
    always @(negedge clk) begin
        entry_t e;
        logic   accept;
        logic   expRd;
        if (!rst) begin
            chk("rst_valid", 32'(tlp_valid), 32'd0);
            chk("rst_sop",   32'(tlp_sop),   32'd0);
            chk("rst_eop",   32'(tlp_eop),   32'd0);
            chk("rst_data",  tlp_data,       32'd0);
            chk("rst_done",  32'(pkt_done),  32'd0);
            chk("rst_count", 32'(pkt_count), 32'd0);
            chk("rst_busy",  32'(busy),      32'd0);
            chk("rst_rden",  32'(fifo_rd_en), 32'd0);
            fifoQ.delete();
            expQ.delete();
            mValid = 1'b0; mSop = 1'b0; mEop = 1'b0; mBusy = 1'b0; mDone = 1'b0;
            mData  = 32'd0; mCount = 3'd0;
        end else begin
            chk("valid", 32'(tlp_valid), 32'(mValid));
            if (mValid) begin
                chk("data", tlp_data, mData);
                chk("sop",  32'(tlp_sop), 32'(mSop));
                chk("eop",  32'(tlp_eop), 32'(mEop));
            end
            chk("busy",      32'(busy),      32'(mBusy));
            chk("pkt_done",  32'(pkt_done),  32'(mDone));
            chk("pkt_count", 32'(pkt_count), 32'(mCount));
            expRd = !fifo_empty && (!mValid || tlp_ready);
            chk("rd_en", 32'(fifo_rd_en), 32'(expRd));
            accept = mValid && tlp_ready;
            if (accept) begin
                if (expQ.size() == 0) begin
                    chk("accept_unexpected", 32'd1, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    chk("order_data", tlp_data, e.data);
                    chk("order_sop", 32'(tlp_sop), 32'(e.first));
                    chk("order_eop", 32'(tlp_eop), 32'(e.last));
                end
                if (mBusy) accBusy++;
            end
            mDone = accept && mEop;
            if (mDone) mCount = mCount + 3'd1;
            if (fifo_rd_en) begin
                if (fifoQ.size() == 0) begin
                    chk("pop_empty", 32'd1, 32'd0);
                end else begin
                    e = fifoQ.pop_front();
                    mValid = 1'b1;
                    mData  = e.data;
                    mSop   = e.first;
                    mEop   = e.last;
                    mBusy  = !e.last;
                    popCnt++;
                end
            end else if (accept) begin
                mValid = 1'b0;
            end
        end
    end

    // Scenario driver.
    initial begin
        int n;
        int base;
        int pushed;
        logic [31:0] w;
        rst = 1'b0; tlp_ready = 1'b0; starve = 1'b0;
        fifo_empty = 1'b1; fifo_data = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        chk("len_3dw",   32'(tlpWords(32'h0000_0001)), 32'd3);
        chk("len_4dw2",  32'(tlpWords(32'h6000_0002)), 32'd6);
        chk("len_1024",  32'(tlpWords(32'h4000_0000)), 32'd1027);
        chk("len_4dw1",  32'(tlpWords(32'h6000_0001)), 32'd5);

        // Single 3DW no-data packet.
        tlp_ready = 1'b1;
        pushTlp(32'h0000_0001);
        waitDrain(100);
        chk("count_3dw", 32'(pkt_count), 32'd1);

        // 4DW write then 3DW packet back-to-back: 9 beats on 9 cycles.
        pushTlp(32'h6000_0002);
        pushTlp(32'h0000_0001);
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (expQ.size() != 0 && n < 100);
        chk("b2b_cycles", 32'(n), 32'd10);
        waitDrain(100);
        chk("count_b2b", 32'(pkt_count), 32'd3);

        // Maximum-length payload.
        accBusy = 0;
        pushTlp(32'h4000_0000);
        waitDrain(3000);
        chk("busy_accepts", 32'(accBusy), 32'd1026);
        chk("count_max", 32'(pkt_count), 32'd4);

        // Downstream stall for 5 cycles mid-packet.
        base = popCnt;
        pushTlp(32'h6000_0002);
        waitPops(base, 2);
        tlp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #3 chk("stall_rd_en", 32'(fifo_rd_en), 32'd0);
        repeat (2) @(posedge clk);
        #1 tlp_ready = 1'b1;
        waitDrain(100);
        chk("count_stall", 32'(pkt_count), 32'd5);

        // Buffer runs dry for 4 cycles mid-packet.
        base = popCnt;
        pushTlp(32'h6000_0001);
        waitPops(base, 2);
        starve = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("starve_valid", 32'(tlp_valid), 32'd0);
        chk("starve_busy",  32'(busy),      32'd1);
        @(posedge clk);
        #1 starve = 1'b0;
        waitDrain(100);
        chk("count_starve", 32'(pkt_count), 32'd6);

        // Reset in the middle of a 4DW packet, then a fresh 3DW packet.
        base = popCnt;
        pushTlp(32'h6000_0003);
        waitPops(base, 2);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        pushTlp(32'h0000_0001);
        waitDrain(100);
        chk("count_after_rst", 32'(pkt_count), 32'd1);
        chk("busy_after_rst",  32'(busy),      32'd0);

        // Randomized traffic with backpressure and starvation.
        pushed = 0;
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            tlp_ready = ($urandom % 4) != 0;
            starve    = ($urandom % 6) == 0;
            if (fifoQ.size() < 3 && pushed < 40) begin
                w = $urandom;
                w[30:29] = 2'($urandom_range(0, 3));
                w[9:0]   = 10'($urandom_range(0, 6));
                if (w[30] && w[9:0] == 10'd0) w[9:0] = 10'd1;
                pushTlp(w);
                pushed++;
            end
        end
        waitDrain(2000);
        chk("count_random", 32'(pkt_count), 32'(3'(1 + pushed)));

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

    // Hard stop if the run ever wedges.
    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
